hamming_secded_pipe: RTL

Parametrised, pipelined Hamming SECDED (single-error-correct, double-error-detect) codec with per-word encode/decode mode, valid/ready handshaking on both sides, and saturating error-statistics counters. It is the streaming successor to the team's combinational Hamming(15,11) encoder. The codeword layout is kept bit-compatible with that encoder in its low 2^r−1 bits, and one extra overall-parity MSB is added. It sits between a data producer and a storage or link channel, and is used on both the write path (encode) and the read path (decode).

---
 rtl/hamming_secded_pipe.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hamming_secded_pipe.sv
// Two-stage pipelined Hamming SECDED codec with per-word encode/decode mode,
// valid/ready on both sides and saturating corrected/uncorrectable counters.
module hamming_secded_pipe #(
  parameter int DATA_W = 11,
  parameter int CNT_W  = 16,
  localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CODE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mode,
  output logic [CODE_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic [PAR_W-1:0]  out_syndrome,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam int HAM_W = CODE_W - 1;

  // Data bit index held by non-power-of-two position p (positions 1..HAM_W).
  function automatic int data_idx(input int p);
    return p - $clog2(p + 1) - 1;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Positions whose index has bit k set, as a bit vector (bit p-1 for position p).
  function automatic logic [HAM_W-1:0] grp_mask(input int k);
    logic [HAM_W-1:0] m;
    m = '0;
    for (int p = HAM_W; p >= 1; p--) begin
      m = {m[HAM_W-2:0], ((p >> k) & 1) == 1};
    end
    return m;
  endfunction

  // Pipeline state
  logic              s1_valid_reg;
  logic              s1_mode_reg;
  logic [CODE_W-1:0] s1_word_reg;
  logic [PAR_W-1:0]  s1_syn_reg;
  logic              s1_q_reg;

  logic              out_valid_reg;
  logic              out_mode_reg;
  logic [CODE_W-1:0] out_data_reg;
  logic [1:0]        out_err_reg;
  logic [PAR_W-1:0]  out_syn_reg;
  logic [CNT_W-1:0]  cnt_corr_reg;
  logic [CNT_W-1:0]  cnt_uncorr_reg;

  // Combinational datapath
  logic [HAM_W-1:0]  enc_base;
  logic [HAM_W-1:0]  enc_ham;
  logic [PAR_W-1:0]  enc_syn;
  logic [PAR_W-1:0]  in_syn;
  logic [CODE_W-1:0] s1_word_next;
  logic [HAM_W-1:0]  dec_flip;
  logic [HAM_W-1:0]  dec_fixed;
  logic [DATA_W-1:0] dec_data;
  logic              dec_syn_nz;
  logic [CODE_W-1:0] out_data_next;
  logic [1:0]        out_err_next;
  logic [PAR_W-1:0]  out_syn_next;

  logic s2_load;
  logic s1_load;
  logic accept;
  logic out_hs;

  genvar gi;

  generate
    for (gi = 1; gi <= HAM_W; gi++) begin : g_pos
      if (is_pow2(gi)) begin : g_par
        // Parity position 2^k takes syndrome bit k of the data-only vector,
        // which zeroes the syndrome of the finished codeword.
        assign enc_base[gi-1] = 1'b0;
        assign enc_ham[gi-1]  = enc_syn[$clog2(gi)];
      end else begin : g_dat
        assign enc_base[gi-1]           = in_data[data_idx(gi)];
        assign enc_ham[gi-1]            = in_data[data_idx(gi)];
        assign dec_data[data_idx(gi)]   = dec_fixed[gi-1];
      end
      assign dec_flip[gi-1] = s1_q_reg && (s1_syn_reg == PAR_W'(gi));
    end

    for (gi = 0; gi < PAR_W; gi++) begin : g_syn
      localparam logic [HAM_W-1:0] MASK = grp_mask(gi);
      assign enc_syn[gi] = ^(enc_base & MASK);
      assign in_syn[gi]  = ^(in_data[HAM_W-1:0] & MASK);
    end
  endgenerate

  assign s1_word_next = in_mode ? in_data : {^enc_ham, enc_ham};
  assign dec_fixed    = s1_word_reg[HAM_W-1:0] ^ dec_flip;
  assign dec_syn_nz   = (s1_syn_reg != '0);

  always_comb begin
    out_data_next = s1_word_reg;
    out_err_next  = 2'b00;
    out_syn_next  = '0;
    if (s1_mode_reg) begin
      out_data_next = {{(CODE_W-DATA_W){1'b0}}, dec_data};
      out_syn_next  = s1_syn_reg;
      if (s1_q_reg) begin
        out_err_next = dec_syn_nz ? 2'b01 : 2'b11;
      end else begin
        out_err_next = dec_syn_nz ? 2'b10 : 2'b00;
      end
    end
  end

  // Handshake: S2 refills when empty or draining; S1 when empty or moving on.
  assign s2_load  = !out_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load && !rst;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid_reg && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_mode_reg   <= 1'b0;
      s1_word_reg   <= '0;
      s1_syn_reg    <= '0;
      s1_q_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      out_mode_reg  <= 1'b0;
      out_data_reg  <= '0;
      out_err_reg   <= 2'b00;
      out_syn_reg   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= accept;
        if (accept) begin
          s1_mode_reg <= in_mode;
          s1_word_reg <= s1_word_next;
          s1_syn_reg  <= in_syn;
          s1_q_reg    <= ^in_data;
        end
      end
      if (s2_load) begin
        out_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          out_mode_reg <= s1_mode_reg;
          out_data_reg <= out_data_next;
          out_err_reg  <= out_err_next;
          out_syn_reg  <= out_syn_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
    end else if (clr_cnt) begin
      cnt_corr_reg   <= '0;
      cnt_uncorr_reg <= '0;
    end else if (out_hs && out_mode_reg) begin
      if (out_err_reg[0] && (cnt_corr_reg != '1)) begin
        cnt_corr_reg <= cnt_corr_reg + 1'b1;
      end
      if ((out_err_reg == 2'b10) && (cnt_uncorr_reg != '1)) begin
        cnt_uncorr_reg <= cnt_uncorr_reg + 1'b1;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_mode     = out_mode_reg;
  assign out_data     = out_data_reg;
  assign out_err      = out_err_reg;
  assign out_syndrome = out_syn_reg;
  assign cnt_corr     = cnt_corr_reg;
  assign cnt_uncorr   = cnt_uncorr_reg;

endmodule
